utf8_uart_tx: RTL

//   Transmit side of the UTF-8-over-UART link. Accepts one 16-bit BMP code point per handshake.

---
 rtl/utf8_uart_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/utf8_uart_tx.sv
// UTF-8 encoder + 8N1 UART transmitter: one BMP code point in, 1..3 back-to-back frames out on tx.
// Optional macro UTF8_TX_SURROGATE_FIX_EN replaces surrogates D800..DFFF with U+FFFD on accept.
module utf8_uart_tx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] code_point,
  input  logic        valid,
  output logic        ready,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  byte_len
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        left_q, left_d;
  logic [1:0]        len_q, len_d;
  logic [23:0]       buf_q, buf_d;
  logic              done_q, done_d;
  logic              tx_q, tx_d;
  logic [15:0]       cp_eff;
  logic [7:0]        cur_byte_d;
  logic              baud_last;

  function automatic logic [1:0] utf8_len(input logic [15:0] cp);
    if (cp < 16'h0080)      return 2'd1;
    else if (cp < 16'h0800) return 2'd2;
    else                    return 2'd3;
  endfunction

  // Lead byte is left-justified in [23:16] so the shifter always sends bits [23:16].
  function automatic logic [23:0] utf8_pack(input logic [15:0] cp);
    if (cp < 16'h0080)      return {1'b0, cp[6:0], 16'h0000};
    else if (cp < 16'h0800) return {3'b110, cp[10:6], 2'b10, cp[5:0], 8'h00};
    else                    return {4'b1110, cp[15:12], 2'b10, cp[11:6], 2'b10, cp[5:0]};
  endfunction

`ifdef UTF8_TX_SURROGATE_FIX_EN
  assign cp_eff = (code_point >= 16'hD800 && code_point <= 16'hDFFF) ? 16'hFFFD : code_point;
`else
  assign cp_eff = code_point;
`endif

  assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    left_d  = left_q;
    len_d   = len_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          buf_d   = utf8_pack(cp_eff);
          len_d   = utf8_len(cp_eff);
          left_d  = utf8_len(cp_eff);
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (left_q == 2'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            left_d  = left_q - 2'd1;
            buf_d   = {buf_q[15:0], 8'h00};
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from next-state values so the pin never glitches.
  assign cur_byte_d = buf_d[23:16];
  always_comb begin
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = cur_byte_d[bit_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      left_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      left_q  <= left_d;
      len_q   <= len_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign byte_len = len_q;
  assign tx       = tx_q;

endmodule
